// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: sequences a solved knight's tour into Y/X motion commands with a valid/ready handshake.
// Define TOUR_FANFARE_EN to issue the X leg of every move with the fanfare opcode (4'h3).
module tour_cmd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [2:0]  x_start,
    input  logic [2:0]  y_start,
    input  logic        abort,
    output logic [2:0]  tour_x,
    output logic [2:0]  tour_y,
    output logic        tour_go,
    input  logic        tour_done,
    output logic [4:0]  indx,
    input  logic [7:0]  move,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    input  logic        cmd_rdy,
    output logic        busy,
    output logic        tour_cmplt,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, CALC, LOAD, SEND_Y, SEND_X, NEXT, ERR} state_t;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] X_OP = 4'h3;
`else
    localparam logic [3:0] X_OP = 4'h2;
`endif
    state_t      state_q, state_d;
    logic [2:0]  tour_x_q, tour_x_d, tour_y_q, tour_y_d;
    logic [4:0]  indx_q, indx_d;
    logic [7:0]  move_q, move_d;
    logic [15:0] cmd_q, cmd_d;
    logic        tour_go_q, tour_go_d, cmd_vld_q, cmd_vld_d, busy_q, busy_d;
    logic        tour_cmplt_q, tour_cmplt_d, err_q, err_d;

    // Positive-y moves are bits 0,1,2,7; two-square y moves are bits 0,1,4,5.
    function automatic logic [15:0] cmd_y(input logic [7:0] m);
        return {4'h2, (m[0] | m[1] | m[2] | m[7]) ? 8'h00 : 8'h7F,
                (m[0] | m[1] | m[4] | m[5]) ? 4'd2 : 4'd1};
    endfunction

    function automatic logic [15:0] cmd_x(input logic [7:0] m);
        return {X_OP, (m[1] | m[5] | m[6] | m[7]) ? 8'hBF : 8'h3F,
                (m[2] | m[3] | m[6] | m[7]) ? 4'd2 : 4'd1};
    endfunction

    always_comb begin
        state_d      = state_q;
        tour_x_d     = tour_x_q;
        tour_y_d     = tour_y_q;
        indx_d       = indx_q;
        move_d       = move_q;
        cmd_d        = cmd_q;
        cmd_vld_d    = cmd_vld_q;
        err_d        = err_q;
        tour_go_d    = 1'b0;
        tour_cmplt_d = 1'b0;
        case (state_q)
            IDLE: if (start_tour) begin
                tour_x_d  = x_start;
                tour_y_d  = y_start;
                indx_d    = 5'd0;
                err_d     = 1'b0;
                tour_go_d = 1'b1;
                state_d   = CALC;
            end
            CALC: if (tour_done) state_d = LOAD;
            LOAD: begin
                move_d = move;
                if ($onehot(move)) begin
                    cmd_d     = cmd_y(move);
                    cmd_vld_d = 1'b1;
                    state_d   = SEND_Y;
                end else begin
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            SEND_Y: if (cmd_rdy) begin
                cmd_d   = cmd_x(move_q);
                state_d = SEND_X;
            end
            SEND_X: if (cmd_rdy) begin
                cmd_vld_d = 1'b0;
                state_d   = NEXT;
            end
            NEXT: if (indx_q != 5'd23) begin
                indx_d  = indx_q + 5'd1;
                state_d = LOAD;
            end else begin
                tour_cmplt_d = 1'b1;
                state_d      = IDLE;
            end
            default: ;
        endcase
        // Abort outranks every other transition, including a pending error or completion.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            cmd_vld_d    = 1'b0;
            tour_cmplt_d = 1'b0;
            err_d        = err_q;
            indx_d       = indx_q;
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tour_x_q     <= '0;
            tour_y_q     <= '0;
            indx_q       <= '0;
            move_q       <= '0;
            cmd_q        <= '0;
            cmd_vld_q    <= 1'b0;
            err_q        <= 1'b0;
            tour_go_q    <= 1'b0;
            tour_cmplt_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tour_x_q     <= tour_x_d;
            tour_y_q     <= tour_y_d;
            indx_q       <= indx_d;
            move_q       <= move_d;
            cmd_q        <= cmd_d;
            cmd_vld_q    <= cmd_vld_d;
            err_q        <= err_d;
            tour_go_q    <= tour_go_d;
            tour_cmplt_q <= tour_cmplt_d;
            busy_q       <= busy_d;
        end
    end

    assign tour_x     = tour_x_q;
    assign tour_y     = tour_y_q;
    assign indx       = indx_q;
    assign cmd        = cmd_q;
    assign cmd_vld    = cmd_vld_q;
    assign err        = err_q;
    assign tour_go    = tour_go_q;
    assign tour_cmplt = tour_cmplt_q;
    assign busy       = busy_q;
endmodule

// File: doc/tour_cmd_seq.md
TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start_tour  in  1  request to compute and execute a tour, sampled in IDLE only.
REQ-004 SHALL have ports: x_start, y_start  in  3 each  starting square, latched with start_tour.
REQ-005 SHALL have port: abort  in  1  synchronous cancel.
REQ-006 SHALL have ports: tour_x, tour_y  out  3 each  latched start square to the tour solver.
REQ-007 SHALL have ports: tour_go  out  1  one-cycle solver start; tour_done  in  1  solver completion pulse.
REQ-008 SHALL have ports: indx  out  5  move index to solver; move  in  8  one-hot move at indx, combinational from indx.
REQ-009 SHALL have ports: cmd  out  16  motion command; cmd_vld  out  1; cmd_rdy  in  1.
REQ-010 SHALL have ports: busy  out  1; tour_cmplt  out  1  one-cycle pulse; err  out  1  sticky bad-move flag.

Function
REQ-011 SHALL implement states IDLE, CALC, LOAD, SEND_Y, SEND_X, NEXT, ERR.
REQ-012 IDLE: start_tour=1 SHALL latch x_start/y_start, clear indx to 0, and go to CALC; tour_go SHALL be high exactly the first CALC cycle.
REQ-013 CALC: SHALL wait indefinitely for tour_done=1, then go to LOAD.
REQ-014 LOAD: SHALL register move (at current indx) in one cycle; a non-one-hot value SHALL set err and go to ERR; otherwise go to SEND_Y.
REQ-015 Move decode (dx,dy) by bit: 0(-1,+2) 1(+1,+2) 2(-2,+1) 3(-2,-1) 4(-1,-2) 5(+1,-2) 6(+2,-1) 7(+2,+1).
REQ-016 cmd SHALL be {opcode[3:0], heading[7:0], squares[3:0]}; move opcode 4'h2.
REQ-017 Headings: +y 8'h00, -y 8'h7F, +x 8'hBF, -x 8'h3F; squares = |dy| for SEND_Y, |dx| for SEND_X.
REQ-018 SEND_Y then SEND_X: cmd_vld SHALL be high in each; cmd SHALL be stable while cmd_vld=1; leave the state on the cycle cmd_vld&cmd_rdy=1.
REQ-019 cmd_rdy already high on entry SHALL complete transfer that same cycle (one cycle per leg minimum).
REQ-020 NEXT: indx<23 SHALL increment indx and go to LOAD; indx=23 SHALL pulse tour_cmplt one cycle and go to IDLE with indx held at 23.
REQ-021 busy SHALL be high in every state except IDLE; start_tour while busy SHALL be ignored.
REQ-022 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, dropping cmd_vld, with no tour_cmplt; abort has priority over all other transitions.
REQ-023 ERR SHALL hold cmd_vld=0 until abort, then go to IDLE; err SHALL clear only on reset or next accepted start_tour.
REQ-024 tour_done outside CALC SHALL be ignored.

Reset
REQ-025 On rst_n=0: state IDLE; tour_go, cmd_vld, busy, tour_cmplt, err=0; indx, tour_x, tour_y=0; cmd=16'h0000.
REQ-026 Reset mid-transfer SHALL drop cmd_vld immediately (asynchronously) with no further commands after release.

Configuration
REQ-027 Macro TOUR_FANFARE_EN defined: SEND_X leg of every move SHALL use opcode 4'h3 (move with fanfare); SEND_Y leg unchanged.
REQ-028 Macro TOUR_FANFARE_EN undefined: both legs SHALL use opcode 4'h2; no other behaviour differs.

Verification
REQ-029 start_tour with (2,2), tour_done after 10 cycles, move=8'h01, cmd_rdy=1 -> tour_go one pulse; cmds 16'h2002 then 16'h23F1.
REQ-030 24 valid moves, cmd_rdy=1 -> exactly 48 handshakes, indx 0..23, one tour_cmplt pulse, busy falls same cycle as return to IDLE.
REQ-031 cmd_rdy held low 5 cycles in SEND_Y -> cmd_vld high and cmd unchanged all 5 cycles, one transfer only.
REQ-032 move=8'h03 at indx 4 -> err=1, state ERR, no cmd_vld; abort -> IDLE next cycle, err stays 1 until new start_tour.
REQ-033 abort during SEND_X at indx 10 -> cmd_vld 0 next cycle, busy 0, no tour_cmplt; start_tour during busy ignored.
REQ-034 TOUR_FANFARE_EN defined, move=8'h80 -> cmds 16'h2001 then 16'h3BF2.
